// File: rtl/clk_divider_multi.sv
// clk_divider_multi: NUM_CH independent runtime-programmable integer clock
// dividers. Each channel produces a registered divided clock and a one-cycle
// tick at every rising edge. New divisors are staged in a shadow register and
// applied only at a period boundary (or immediately while the channel is idle).
module clk_divider_multi #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 100,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] cfg_pending
);

    // Divisors below 2 cannot produce a clock, so they are raised to 2.
    localparam logic [DIV_W-1:0] RST_DIV = (DEFAULT_DIV < 2) ? DIV_W'(2) : DIV_W'(DEFAULT_DIV);

    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] v);
        return (v < DIV_W'(2)) ? DIV_W'(2) : v;
    endfunction

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DIV_W-1:0] div_q, div_d;   // active divisor
        logic [DIV_W-1:0] shd_q, shd_d;   // shadow divisor awaiting a boundary
        logic [DIV_W-1:0] cnt_q, cnt_d;   // position within the period, 0..div-1
        logic             pend_q, pend_d;
        logic             clk_q, clk_d;
        logic             tick_q, tick_d;
        logic             wr;
        logic             at_end;
        logic [DIV_W-1:0] cnt_nxt;
        logic [DIV_W:0]   half;           // ceil(div/2), one bit wider so div+1 cannot wrap

        // Out-of-range channel indices never match any channel, so such writes vanish.
        assign wr = cfg_we && (cfg_ch == CH_W'(i));

        // Next-state: count while enabled, swap divisor at period end, park when disabled.
        always_comb begin
            div_d   = div_q;
            shd_d   = shd_q;
            pend_d  = pend_q;
            cnt_d   = cnt_q;
            clk_d   = 1'b0;
            tick_d  = 1'b0;
            at_end  = (cnt_q == div_q - DIV_W'(1));
            cnt_nxt = at_end ? '0 : cnt_q + DIV_W'(1);
            half    = ({1'b0, div_q} + (DIV_W+1)'(1)) >> 1;
            if (en[i]) begin
                cnt_d  = cnt_nxt;
                // cnt_nxt is 0 at a boundary, so the high phase always starts cleanly
                clk_d  = ({1'b0, cnt_nxt} < half);
                tick_d = (cnt_nxt == '0);
                if (at_end && pend_q) begin
                    div_d  = shd_q;
                    pend_d = 1'b0;
                end
            end else begin
                // Park at the last count so re-enable begins a fresh period next cycle
                cnt_d = div_q - DIV_W'(1);
                if (pend_q) begin
                    div_d  = shd_q;
                    cnt_d  = shd_q - DIV_W'(1);
                    pend_d = 1'b0;
                end
            end
            // A write landing on a boundary leaves the old shadow applied and re-arms pending
            if (wr) begin
                shd_d  = clamp_div(cfg_div);
                pend_d = 1'b1;
            end
        end

        // Channel state registers with asynchronous reset to the default divisor.
        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                div_q  <= RST_DIV;
                shd_q  <= RST_DIV;
                cnt_q  <= RST_DIV - DIV_W'(1);
                pend_q <= 1'b0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                div_q  <= div_d;
                shd_q  <= shd_d;
                cnt_q  <= cnt_d;
                pend_q <= pend_d;
                clk_q  <= clk_d;
                tick_q <= tick_d;
            end
        end

        assign clk_out[i]     = clk_q;
        assign tick[i]        = tick_q;
        assign cfg_pending[i] = pend_q;
    end

endmodule

// File: doc/clk_divider_multi.md
Name: clk_divider_multi

Overview:
- Multi-channel, runtime-programmable clock divider. Successor to the fixed single-output divider.
- Each of NUM_CH channels divides clk_in by its own integer divisor D (2..2^DIV_W-1), odd or even. Each channel produces a registered divided clock plus a one-cycle tick strobe.
- Divisors are written through a simple config port and take effect only at a period boundary, so there are no runt pulses. Per-channel enable parks the output low.
- Sits between the system clock and slow peripheral timing consumers (sensor sampling, display refresh, UART baud).

Parameters:
NUM_CH, 4, number of independent divider channels (>=1)
DIV_W, 16, divisor width in bits
DEFAULT_DIV, 100, divisor loaded into every channel at reset; values <2 are treated as 2
(localparam CH_W = max(1, $clog2(NUM_CH)))

Ports:
clk_in  input  1  system clock; all logic on its rising edge
rst_n  input  1  asynchronous active-low reset
en  input  NUM_CH  per-channel run enable, bit i = channel i
cfg_we  input  1  config write strobe, one cycle per write
cfg_ch  input  CH_W  channel index for the write
cfg_div  input  DIV_W  new divisor
clk_out  output  NUM_CH  divided clock outputs, registered
tick  output  NUM_CH  one-clk_in-cycle pulse coincident with each clk_out rising edge
cfg_pending  output  NUM_CH  channel i has a written divisor not yet applied

Behaviour:
- Interface: one clock, clk_in. Reset rst_n is asynchronous, active-low.
- Per-channel state:
  - active divisor D
  - shadow divisor P
  - pending flag
  - counter cnt (DIV_W bits, range 0..D-1)
  - clk_out, tick registers
- Reset (asserts asynchronously at any time, including mid-period or mid-config):
  - D = P = max(DEFAULT_DIV, 2); cnt = D-1; pending = 0.
  - clk_out = 0, tick = 0, cfg_pending = 0.
- Run cycle, en[i]=1:
  - cnt_n = (cnt == D-1) ? 0 : cnt+1.
  - clk_out <= (cnt_n < H), where H = ceil(D/2). High time = ceil(D/2) cycles, low time = floor(D/2) cycles. Period is exactly D cycles.
  - tick <= (cnt_n == 0).
  - The first enabled cycle after reset gives cnt_n = 0, so clk_out rises and tick pulses one cycle after the first enabled edge.
- Divisor update:
  - cfg_we=1 with cfg_ch < NUM_CH: P <= clamp(cfg_div), where values 0 and 1 become 2; pending <= 1.
  - cfg_ch >= NUM_CH: write ignored, no state change.
  - Writes are always accepted; there is no back-pressure. A later write before the boundary overwrites P (last write wins).
  - Boundary (channel enabled, cnt == D-1, pending == 1): D <= P, pending <= 0, cnt <= 0. clk_out rises, and the new high/low times apply from this period on.
  - Simultaneous write and boundary on the same channel: the boundary applies the old P. The new value becomes P, and pending stays 1 for the next boundary.
- Disable, en[i]=0:
  - cnt <= D-1, clk_out <= 0, tick <= 0.
  - If pending, D <= P and pending <= 0 immediately, and cnt parks at P-1.
  - Re-enable starts a full clean period with the first rising edge on the next cycle. No glitch or partial pulse is produced on enable or disable.
- D = 2 yields clk_in/2 at 50% duty with tick every 2nd cycle. Odd D gives the high phase one extra cycle.
- Channels are fully independent; a write to one channel never perturbs another.
- Counter arithmetic: cnt compared against D-1 at DIV_W bits; no overflow, since D <= 2^DIV_W-1.

Test Plan:
- Reset, all en=1, DEFAULT_DIV=4: every clk_out reads 1,1,0,0 repeating from the first edge; tick high on cycles 1,5,9,...; cfg_pending=0.
- Odd divisor: write ch1 div=5 while ch1 disabled, then enable → clk_out[1] high 3 cycles, low 2; tick period 5; ch0 unaffected.
- Mid-period update: ch0 running D=4 at cnt=1, write div=6 → old period completes (2 more cycles); cfg_pending[0]=1 until the boundary; then 3 high / 3 low; cfg_pending clears on the boundary cycle.
- Boundary collision: write div=8 on the exact cycle ch2 hits cnt=D-1 with P=6 pending → next period is 6, then 8; cfg_pending stays 1 through one period.
- Clamp/ignore: write div=0 to ch3 → D=2 (toggles every cycle); write with cfg_ch=7 (NUM_CH=4, CH_W=2 truncates, so use NUM_CH=5 build) → no channel changes.
- Reset mid-run with clk_out high and a pending write → all outputs 0 immediately (asynchronous), D returns to DEFAULT_DIV, pending lost; en toggle 1→0→1 gives no runt pulse.
